// File: rtl/link_sync_pkg.sv
// rtl/link_sync_pkg.sv - shared codes, window defaults and FSM encoding for link_sync_ctrl
package link_sync_pkg;

   localparam logic [7:0] COMMA_CODE     = 8'hBC;
   localparam logic [7:0] IDLE_CODE      = 8'h7C;
   localparam int         LOCK_CNT_DEF   = 4;
   localparam int         SEARCH_WIN_DEF = 16;
   localparam int         SLIP_HOLD_DEF  = 8;
   localparam int         LOSS_WIN_DEF   = 64;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_CONFIRM   = 2'd1,
      ST_LOCKED    = 2'd2,
      ST_SLIP_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/link_sync_win_cnt.sv
// rtl/link_sync_win_cnt.sv - clearable enabled window counter with terminal-count flag
module link_sync_win_cnt #(
   parameter int TERM = 16
) (
   input  logic clk_4f,
   input  logic reset_L,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int W = $clog2(TERM + 1);

   logic [W-1:0] count;

   // hit flags the enabled increment that would reach TERM; the owner clears on it
   assign hit = en && (count == W'(TERM - 1));

   // clear has priority over counting so a hit restarts the window from zero
   always_ff @(posedge clk_4f) begin
      if (!reset_L || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/link_sync_ctrl.sv
// rtl/link_sync_ctrl.sv - comma-based word alignment and lock controller
module link_sync_ctrl
   import link_sync_pkg::*;
#(
   parameter logic [7:0] COMMA      = COMMA_CODE,
   parameter logic [7:0] IDLE       = IDLE_CODE,
   parameter int         LOCK_CNT   = LOCK_CNT_DEF,
   parameter int         SEARCH_WIN = SEARCH_WIN_DEF,
   parameter int         SLIP_HOLD  = SLIP_HOLD_DEF,
   parameter int         LOSS_WIN   = LOSS_WIN_DEF
) (
   input  logic       clk_4f,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       word_valid,
   output logic       slip,
   output logic       active,
   output logic [2:0] BC_counter,
   output logic [7:0] data_out,
   output logic       valid_out
);

   state_t state;

   logic is_comma;
   logic is_idle;
   logic search_en, search_clr, search_hit;
   logic hold_en, hold_clr, hold_hit;
   logic loss_en, loss_clr, loss_hit;

   assign is_comma = (data_in == COMMA);
   assign is_idle  = (data_in == IDLE);

   // Window counters run only in their own state and are held at zero elsewhere,
   // so every entry into a state starts a fresh window.
   assign search_en  = (state == ST_SEARCH) && word_valid && !is_comma;
   assign search_clr = (state != ST_SEARCH) || (word_valid && is_comma) || search_hit;

   assign hold_en    = (state == ST_SLIP_WAIT);
   assign hold_clr   = (state != ST_SLIP_WAIT) || hold_hit;

   assign loss_en    = (state == ST_LOCKED) && word_valid && !is_comma;
   assign loss_clr   = (state != ST_LOCKED) || (word_valid && is_comma) || loss_hit;

   link_sync_win_cnt #(.TERM(SEARCH_WIN)) u_search_cnt (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .clr     (search_clr),
      .en      (search_en),
      .hit     (search_hit)
   );

   link_sync_win_cnt #(.TERM(SLIP_HOLD)) u_hold_cnt (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .clr     (hold_clr),
      .en      (hold_en),
      .hit     (hold_hit)
   );

   link_sync_win_cnt #(.TERM(LOSS_WIN)) u_loss_cnt (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .clr     (loss_clr),
      .en      (loss_en),
      .hit     (loss_hit)
   );

   // Alignment FSM; slip and valid_out are single-cycle pulses defaulting low each clock
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         state      <= ST_SEARCH;
         slip       <= 1'b0;
         active     <= 1'b0;
         BC_counter <= 3'd0;
         data_out   <= 8'h00;
         valid_out  <= 1'b0;
      end else begin
         slip      <= 1'b0;
         valid_out <= 1'b0;
         case (state)
            ST_SEARCH: begin
               if (word_valid) begin
                  if (is_comma) begin
                     BC_counter <= 3'd1;
                     if (LOCK_CNT == 1) begin
                        state  <= ST_LOCKED;
                        active <= 1'b1;
                     end else begin
                        state <= ST_CONFIRM;
                     end
                  end else if (search_hit) begin
                     slip  <= 1'b1;
                     state <= ST_SLIP_WAIT;
                  end
               end
            end
            ST_CONFIRM: begin
               if (word_valid) begin
                  if (is_comma) begin
                     BC_counter <= BC_counter + 3'd1;
                     if (BC_counter == 3'(LOCK_CNT - 1)) begin
                        state  <= ST_LOCKED;
                        active <= 1'b1;
                     end
                  end else begin
                     BC_counter <= 3'd0;
                     state      <= ST_SEARCH;
                  end
               end
            end
            ST_LOCKED: begin
               if (word_valid) begin
                  if (loss_hit) begin
                     state      <= ST_SEARCH;
                     active     <= 1'b0;
                     BC_counter <= 3'd0;
                  end else if (!is_comma && !is_idle) begin
                     data_out  <= data_in;
                     valid_out <= 1'b1;
                  end
               end
            end
            ST_SLIP_WAIT: begin
               if (hold_hit) begin
                  state      <= ST_SEARCH;
                  BC_counter <= 3'd0;
               end
            end
            default: state <= ST_SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_link_sync_ctrl.sv
// tb/tb_link_sync_ctrl.sv - self-checking bench for link_sync_ctrl
module tb_link_sync_ctrl;

   localparam logic [7:0] COMMA      = 8'hBC;
   localparam logic [7:0] IDLE       = 8'h7C;
   localparam int         LOCK_CNT   = 4;
   localparam int         SEARCH_WIN = 16;
   localparam int         SLIP_HOLD  = 8;
   localparam int         LOSS_WIN   = 64;

   logic       clk_4f;
   logic       reset_L;
   logic [7:0] data_in;
   logic       word_valid;
   logic       slip;
   logic       active;
   logic [2:0] BC_counter;
   logic [7:0] data_out;
   logic       valid_out;

   int n_vec;
   int n_err;

   link_sync_ctrl dut (
      .clk_4f     (clk_4f),
      .reset_L    (reset_L),
      .data_in    (data_in),
      .word_valid (word_valid),
      .slip       (slip),
      .active     (active),
      .BC_counter (BC_counter),
      .data_out   (data_out),
      .valid_out  (valid_out)
   );

   initial begin
      clk_4f = 1'b0;
      forever #5 clk_4f = ~clk_4f;
   end

   // reference model: link behaviour in terms of runs of commas and misses
   localparam int HUNT = 0, CONF = 1, LOCK = 2, HOLD = 3;
   int         m_mode, m_miss, m_hold, m_run, m_loss;
   logic       m_slip, m_vout;
   logic [7:0] m_dout;

   task automatic model_update(input logic rn, input logic wv, input logic [7:0] d);
      m_slip = 1'b0;
      m_vout = 1'b0;
      if (!rn) begin
         m_mode = HUNT; m_miss = 0; m_hold = 0; m_run = 0; m_loss = 0; m_dout = 8'h00;
      end else if (m_mode == HOLD) begin
         m_hold++;
         if (m_hold == SLIP_HOLD) begin
            m_mode = HUNT; m_hold = 0; m_miss = 0; m_run = 0;
         end
      end else if (wv) begin
         if (d == COMMA) begin
            m_loss = 0;
            m_miss = 0;
            if (m_run < LOCK_CNT) m_run++;
            m_mode = (m_run == LOCK_CNT) ? LOCK : CONF;
         end else if (m_mode == LOCK) begin
            m_loss++;
            if (m_loss == LOSS_WIN) begin
               m_mode = HUNT; m_run = 0; m_loss = 0;
            end else if (d != IDLE) begin
               m_vout = 1'b1;
               m_dout = d;
            end
         end else if (m_mode == CONF) begin
            m_run  = 0;
            m_mode = HUNT;
         end else begin
            m_miss++;
            if (m_miss == SEARCH_WIN) begin
               m_slip = 1'b1; m_mode = HOLD; m_miss = 0;
            end
         end
      end
   endtask

   function automatic logic [13:0] dut_out();
      return {slip, active, BC_counter, valid_out, data_out};
   endfunction

   function automatic logic [13:0] model_out();
      return {m_slip, (m_mode == LOCK), 3'(m_run), m_vout, m_dout};
   endfunction

   task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (slip,active,bc,vout,dout)", name, act, exp);
      end
   endtask

   // drive one word, clock it, advance the model and sample #1 after the edge
   task automatic tick(input logic rn, input logic wv, input logic [7:0] d);
      reset_L    = rn;
      word_valid = wv;
      data_in    = d;
      @(posedge clk_4f);
      #1;
      model_update(rn, wv, d);
   endtask

   task automatic step(input string name, input logic rn, input logic wv, input logic [7:0] d);
      tick(rn, wv, d);
      chk(name, dut_out(), model_out());
   endtask

   task automatic lock_up();
      step("rst", 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < LOCK_CNT; i++) step("lock", 1'b1, 1'b1, COMMA);
   endtask

   typedef struct {
      logic       rn;
      logic       wv;
      logic [7:0] d;
      logic       e_slip;
      logic       e_act;
      logic [2:0] e_bc;
      logic       e_vout;
      logic [7:0] e_dout;
   } vec_t;

   vec_t tbl[17];

   initial begin
      n_vec = 0;
      n_err = 0;
      reset_L = 1'b0; word_valid = 1'b0; data_in = 8'h00;
      model_update(1'b0, 1'b0, 8'h00);

      //         rn    wv    d      slip  act   bc    vout  dout
      tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 1'b0, 8'hBC, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00};
      tbl[4]  = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00};
      tbl[6]  = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00};
      tbl[7]  = '{1'b1, 1'b1, 8'h7C, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00};
      tbl[8]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd4, 1'b1, 8'hA5};
      tbl[9]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 3'd4, 1'b1, 8'h3C};
      tbl[10] = '{1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 3'd4, 1'b0, 8'h3C};
      tbl[11] = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b1, 3'd4, 1'b0, 8'h3C};
      tbl[12] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
      tbl[13] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
      tbl[14] = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00};
      tbl[15] = '{1'b1, 1'b1, 8'hBC, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00};
      tbl[16] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};

      for (int i = 0; i < 17; i++) begin
         tick(tbl[i].rn, tbl[i].wv, tbl[i].d);
         chk($sformatf("tbl%0d", i), dut_out(),
             {tbl[i].e_slip, tbl[i].e_act, tbl[i].e_bc, tbl[i].e_vout, tbl[i].e_dout});
      end

      // search window exhaustion: single slip, ignored hold period, then normal lock
      step("rst", 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < SEARCH_WIN - 1; i++) step("search", 1'b1, 1'b1, 8'h00);
      tick(1'b1, 1'b1, 8'h00);
      chk("slip_pulse", {13'd0, slip}, 14'd1);
      for (int i = 0; i < SLIP_HOLD; i++) begin
         tick(1'b1, 1'b1, COMMA);
         chk("hold_ignore", {10'd0, slip, BC_counter}, 14'd0);
      end
      for (int i = 0; i < LOCK_CNT; i++) step("relock", 1'b1, 1'b1, COMMA);
      chk("relock_active", {13'd0, active}, 14'd1);

      // reset landing on the slip pulse cycle clears it and restarts the window
      step("rst", 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < SEARCH_WIN; i++) step("search2", 1'b1, 1'b1, 8'h00);
      tick(1'b0, 1'b1, 8'h00);
      chk("rst_on_slip", dut_out(), 14'd0);
      for (int i = 0; i < SEARCH_WIN - 1; i++) step("post_rst", 1'b1, (i % 3) != 1, 8'h00);
      chk("no_slip_after_rst", {13'd0, slip}, 14'd0);

      // loss of lock: 63 misses survive, a comma resets, 64 misses drop
      lock_up();
      for (int i = 0; i < LOSS_WIN - 1; i++) step("loss63", 1'b1, 1'b1, 8'h11);
      chk("still_locked", {13'd0, active}, 14'd1);
      step("loss_comma", 1'b1, 1'b1, COMMA);
      for (int i = 0; i < LOSS_WIN - 1; i++) step("loss64", 1'b1, 1'b1, 8'h11);
      tick(1'b1, 1'b1, 8'h11);
      chk("lock_lost", {10'd0, active, BC_counter}, 14'd0);

      // randomized: comma-rich phase for locking, then comma-poor for slips and loss
      step("rst", 1'b0, 1'b0, 8'h00);
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 2500; i++) begin
            logic [7:0] d;
            int r;
            r = $urandom_range(99);
            if (ph == 0) d = (r < 55) ? COMMA : (r < 70) ? IDLE : 8'($urandom);
            else         d = (r < 3)  ? COMMA : (r < 20) ? IDLE : 8'($urandom);
            step("rand", ($urandom_range(299) != 0), ($urandom_range(9) < 8), d);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/link_sync_ctrl.md
LINK_SYNC_CTRL -- requirements
Module: link_sync_ctrl

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC, alignment/comma character.
REQ-002 SHALL have parameter IDLE, default 8'h7C, idle filler character.
REQ-003 SHALL have parameter LOCK_CNT, default 4, consecutive commas required for lock.
REQ-004 SHALL have parameter SEARCH_WIN, default 16, non-comma words tolerated in SEARCH before a slip.
REQ-005 SHALL have parameter SLIP_HOLD, default 8, clocks to wait after a slip.
REQ-006 SHALL have parameter LOSS_WIN, default 64, consecutive non-comma words in LOCKED that drop lock.
REQ-007 SHALL have port clk_4f  input  1  word clock; one clock only.
REQ-008 SHALL have port reset_L  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port data_in  input  8  deserialized word from the serial-to-parallel stage.
REQ-010 SHALL have port word_valid  input  1  data_in holds a new word this cycle.
REQ-011 SHALL have port slip  output  1  one-cycle request to the deserializer to shift bit alignment by one.
REQ-012 SHALL have port active  output  1  link locked.
REQ-013 SHALL have port BC_counter  output  3  consecutive commas counted toward lock, saturating at LOCK_CNT.
REQ-014 SHALL have port data_out  output  8  payload word.
REQ-015 SHALL have port valid_out  output  1  data_out is valid this cycle.

Function
REQ-016 SHALL implement FSM states SEARCH, CONFIRM, LOCKED, SLIP_WAIT; all outputs registered.
REQ-017 With word_valid=0 in SEARCH/CONFIRM/LOCKED, state, BC_counter and window counters SHALL hold and valid_out SHALL be 0.
REQ-018 SEARCH: valid word == COMMA -> BC_counter=1, window counter cleared, next state CONFIRM.
REQ-019 SEARCH: valid non-comma word increments window counter; on the SEARCH_WIN-th, slip=1 the next cycle for exactly one cycle, next state SLIP_WAIT.
REQ-020 SLIP_WAIT: SHALL ignore all words and count SLIP_HOLD clocks regardless of word_valid, then enter SEARCH with window counter and BC_counter cleared.
REQ-021 CONFIRM: valid COMMA increments BC_counter; when BC_counter reaches LOCK_CNT, next state LOCKED and active=1 on the same edge.
REQ-022 CONFIRM: valid non-comma word -> BC_counter=0, next state SEARCH (no slip).
REQ-023 LOCKED: active=1, BC_counter held at LOCK_CNT (saturated, never wraps).
REQ-024 LOCKED: valid word neither COMMA nor IDLE -> data_out=data_in, valid_out=1 on the next edge (latency 1 clock).
REQ-025 LOCKED: COMMA and IDLE words SHALL give valid_out=0; data_out holds its last value.
REQ-026 LOCKED: COMMA clears the loss counter; any other valid word increments it; on reaching LOSS_WIN, next state SEARCH, active=0, BC_counter=0, loss counter cleared.
REQ-027 slip SHALL be 0 in every state except the single cycle of REQ-019; at most one slip per SLIP_HOLD+1 clocks.
REQ-028 Outside LOCKED, valid_out SHALL be 0 and active SHALL be 0.
REQ-029 Counters SHALL be sized to hold their parameter terminal value without wrap.

Reset
REQ-030 reset_L=0 at a clk_4f edge SHALL force state SEARCH, all counters 0, slip=0, active=0, BC_counter=0, data_out=8'h00, valid_out=0.
REQ-031 Reset asserted mid-operation (any state, including during a slip pulse) SHALL take effect on that edge; no slip is issued after reset.
REQ-032 The first word sampled SHALL be at the first edge with reset_L=1.

Structure
REQ-033 COMMA/IDLE codes, default window constants and state encoding SHALL reside in shared package link_sync_pkg.
REQ-034 A single sub-module link_sync_win_cnt (clearable, enabled counter with terminal-count flag) SHALL be reused for the search, slip-hold and loss windows.

Verification
REQ-035 After reset, 4 consecutive valid 8'hBC -> BC_counter 1,2,3,4; active=1 on the 4th word's edge.
REQ-036 Locked, feed BC,7C,A5,3C -> valid_out only for A5 and 3C, each one clock after input; data_out=A5 then 3C.
REQ-037 16 valid 8'h00 words in SEARCH -> one slip pulse; 8 clocks of ignored input; then commas lock normally.
REQ-038 In CONFIRM with BC_counter=2, word 8'h55 -> BC_counter=0, state SEARCH, slip=0.
REQ-039 Locked, 64 consecutive 8'h11 -> active=0 and BC_counter=0 after the 64th; 63 then BC keeps lock.
REQ-040 reset_L low for one cycle during the slip pulse and while locked -> all outputs 0 next edge; word_valid=0 gaps freeze all counters.
